// File: rtl/irq_vector_ctrl.sv
// Fixed-priority vectored interrupt controller: rising edges latch into pend, are
// masked and arbitrated, and an acknowledge delivers the winner's handler address.
module irq_vector_ctrl #(
    parameter int unsigned       N_IRQ      = 4,
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0000,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 16'h0010,
    localparam int unsigned      ID_W       = $clog2(N_IRQ)
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [N_IRQ-1:0]  in_irq,
    input  logic [N_IRQ-1:0]  in_mask,
    input  logic              in_ie,
    input  logic              in_ack,
    input  logic              in_eoi,
    output logic              out_req,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ID_W-1:0]   out_id,
    output logic [N_IRQ-1:0]  out_pend,
    output logic [N_IRQ-1:0]  out_isr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_IRQ-1:0]  irq_q;
    logic [N_IRQ-1:0]  pend_q, pend_d;
    logic [N_IRQ-1:0]  isr_q, isr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [N_IRQ-1:0]  irq_edge;
    logic [N_IRQ-1:0]  eligible;
    logic [N_IRQ-1:0]  eoi_clr;
    logic [N_IRQ-1:0]  ack_set;
    logic              win_vld;
    logic              blocked;
    logic [ID_W-1:0]   win_id;
    logic              ack_fire;

    assign irq_edge = in_irq & ~irq_q;
    assign eligible = pend_q & ~in_mask & {N_IRQ{in_ie}};

    // Scan from the highest priority down; an in-service bit at or above the
    // candidate's priority stops the scan, which is the preemption rule.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_vld = 1'b0;
        win_id  = '0;
        blocked = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (!win_vld && !blocked) begin
                if (isr_q[i]) begin
                    blocked = 1'b1;
                end else if (eligible[i]) begin
                    win_vld = 1'b1;
                    win_id  = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) state_d = REQ;
            end
            REQ: begin
                if (!win_vld) begin
                    state_d = IDLE;
                end else if (in_ack) begin
                    ack_fire = 1'b1;
                    state_d  = ACK;
                end
            end
            // ACK evaluates the idle transition directly so a new request can
            // be raised two cycles after the acknowledge.
            ACK:     state_d = win_vld ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lowest set bit of isr via two's complement; zero when isr is empty.
    assign eoi_clr = in_eoi   ? (isr_q & (~isr_q + N_IRQ'(1))) : '0;
    assign ack_set = ack_fire ? (N_IRQ'(1) << win_id)          : '0;

    // A fresh edge on the acknowledged channel re-pends it; eoi clears before ack sets.
    assign pend_d = (pend_q & ~ack_set) | irq_edge;
    assign isr_d  = (isr_q & ~eoi_clr) | ack_set;
    assign id_d   = ack_fire ? win_id : id_q;
    assign addr_d = ack_fire ? (VEC_BASE + ADDR_W'(win_id) * VEC_STRIDE) : addr_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= IDLE;
            irq_q   <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            irq_q   <= in_irq;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
        end
    end

    assign out_req  = (state_q == REQ);
    assign out_vld  = (state_q == ACK);
    assign out_addr = addr_q;
    assign out_id   = id_q;
    assign out_pend = pend_q;
    assign out_isr  = isr_q;

endmodule
